// File: rtl/hopfield_seq_ctrl.sv
// Command sequencer for the Hopfield datapath: TRAIN/RECALL in, pulsed datapath controls, response out.
// Optional build macro HOPFIELD_SEQ_STATS_EN adds saturating response statistics counters.
module hopfield_seq_ctrl #(
   parameter int N         = 16,
   parameter int MAX_ITERS = 32,
   parameter int ITER_W    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [N-1:0]      cmd_pattern,
   output logic [N-1:0]      pattern_input,
   output logic              modify_weights,
   output logic              modify_neuron,
   output logic              modify_neuron_using_input,
   input  logic              same_input,
   input  logic              converged,
   input  logic [N-1:0]      neuron_states,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [N-1:0]      rsp_pattern,
   output logic [ITER_W-1:0] rsp_iters,
   output logic              rsp_timeout
`ifdef HOPFIELD_SEQ_STATS_EN
   ,
   output logic [15:0]       stat_trains,
   output logic [15:0]       stat_recalls,
   output logic [15:0]       stat_timeouts
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_TRAIN  = 3'd2;
   localparam logic [2:0] S_INIT   = 3'd3;
   localparam logic [2:0] S_ITER   = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic              op;
   logic [ITER_W-1:0] iter_cnt;
   logic              at_cap;
   logic              rsp_fire;

   assign at_cap   = (iter_cnt == ITER_W'(MAX_ITERS));
   assign rsp_fire = rsp_valid & rsp_ready;

   assign cmd_ready                 = (state == S_IDLE);
   assign rsp_valid                 = (state == S_RESP);
   assign modify_weights            = (state == S_TRAIN);
   assign modify_neuron_using_input = (state == S_INIT);
   // Update pulse in ITER is suppressed combinationally on the cycle convergence is seen.
   assign modify_neuron = (state == S_INIT) |
                          ((state == S_ITER) & ~converged & ~at_cap);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (cmd_valid) state_nxt = S_SETTLE;
         S_SETTLE: if (same_input) state_nxt = op ? S_INIT : S_TRAIN;
         S_TRAIN:  state_nxt = S_RESP;
         S_INIT:   state_nxt = S_ITER;
         S_ITER:   if (converged || at_cap) state_nxt = S_RESP;
         S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         op            <= 1'b0;
         pattern_input <= '0;
         iter_cnt      <= '0;
         rsp_pattern   <= '0;
         rsp_iters     <= '0;
         rsp_timeout   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op            <= cmd_op;
                  pattern_input <= cmd_pattern;
               end
            end
            S_TRAIN: begin
               rsp_pattern <= pattern_input;
               rsp_iters   <= '0;
               rsp_timeout <= 1'b0;
            end
            S_INIT: iter_cnt <= '0;
            S_ITER: begin
               if (converged || at_cap) begin
                  rsp_pattern <= neuron_states;
                  rsp_iters   <= iter_cnt;
                  rsp_timeout <= ~converged;
               end else begin
                  iter_cnt <= iter_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HOPFIELD_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_trains   <= '0;
         stat_recalls  <= '0;
         stat_timeouts <= '0;
      end else if (rsp_fire) begin
         if (!op && stat_trains != 16'hFFFF) stat_trains <= stat_trains + 16'd1;
         if (op && stat_recalls != 16'hFFFF) stat_recalls <= stat_recalls + 16'd1;
         if (op && rsp_timeout && stat_timeouts != 16'hFFFF)
            stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`else
   logic unused_fire;
   assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_hopfield_seq_ctrl.sv
// Self-checking bench for hopfield_seq_ctrl with a behavioural datapath stand-in and response scoreboard.
module tb_hopfield_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_op = 1'b0;
   logic [15:0] cmd_pattern = '0;
   logic [15:0] pattern_input;
   logic        modify_weights;
   logic        modify_neuron;
   logic        modify_neuron_using_input;
   logic        same_input = 1'b0;
   logic        converged = 1'b0;
   logic [15:0] neuron_states = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_pattern;
   logic [5:0]  rsp_iters;
   logic        rsp_timeout;
`ifdef HOPFIELD_SEQ_STATS_EN
   logic [15:0] stat_trains, stat_recalls, stat_timeouts;
`endif

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [15:0] pat;
      logic [5:0]  iters;
      logic        tmo;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   hopfield_seq_ctrl #(.N(16), .MAX_ITERS(4), .ITER_W(6)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pattern(cmd_pattern),
      .pattern_input(pattern_input), .modify_weights(modify_weights),
      .modify_neuron(modify_neuron), .modify_neuron_using_input(modify_neuron_using_input),
      .same_input(same_input), .converged(converged), .neuron_states(neuron_states),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pattern(rsp_pattern),
      .rsp_iters(rsp_iters), .rsp_timeout(rsp_timeout)
`ifdef HOPFIELD_SEQ_STATS_EN
      , .stat_trains(stat_trains), .stat_recalls(stat_recalls), .stat_timeouts(stat_timeouts)
`endif
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Issues one command and plays the datapath until a response appears (or stop_pulses update pulses).
   task automatic run_cmd(input logic op, input logic [15:0] pat, input int settle_wait,
                          input int conv_after, input int stop_pulses,
                          output int mw_cyc, output int mw_cnt, output int init_cnt,
                          output int pulses, output int rsp_cyc, output int overlap,
                          output int pi_bad);
      logic init_seen;
      init_seen = 1'b0;
      mw_cyc = -1; mw_cnt = 0; init_cnt = 0; pulses = 0; rsp_cyc = -1; overlap = 0; pi_bad = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_pattern = pat; same_input = 1'b0; converged = 1'b0;
      for (int t = 1; t <= 60; t++) begin
         @(negedge clk);
         cmd_valid  = 1'b0;
         same_input = (t > settle_wait);
         converged  = init_seen && (pulses >= conv_after);
         #1;
         if (pattern_input !== pat) pi_bad++;
         if (modify_weights && modify_neuron) overlap++;
         if (modify_weights) begin
            mw_cnt++;
            if (mw_cyc < 0) mw_cyc = t;
         end
         if (modify_neuron && modify_neuron_using_input) begin
            init_cnt++;
            init_seen = 1'b1;
         end else if (modify_neuron) begin
            pulses++;
         end
         if (rsp_valid) begin
            rsp_cyc = t;
            break;
         end
         if (stop_pulses > 0 && pulses >= stop_pulses) break;
      end
   endtask

   task automatic consume_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      converged = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({pattern_input, modify_weights, modify_neuron, modify_neuron_using_input,
                     rsp_valid, rsp_pattern, rsp_iters, rsp_timeout} !== '0)
         $display("FAIL reset_outputs: got pi=%h mw=%b mn=%b mnui=%b rv=%b rp=%h ri=%0d rt=%b, required all zero",
                  pattern_input, modify_weights, modify_neuron, modify_neuron_using_input,
                  rsp_valid, rsp_pattern, rsp_iters, rsp_timeout);
      else passed++;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_train();
      int mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad;
      exp_t e;
      sb.push_back('{pat: 16'h00FF, iters: 6'd0, tmo: 1'b0});
      run_cmd(1'b0, 16'h00FF, 0, 0, 0, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      checks++; if (pi_bad != 0) $display("FAIL train_pattern_input: %0d bad cycles, required 0", pi_bad); else passed++;
      checks++; if (mw_cyc != 2) $display("FAIL train_mw_latency: got %0d required 2", mw_cyc); else passed++;
      checks++; if (mw_cnt != 1) $display("FAIL train_mw_width: got %0d required 1", mw_cnt); else passed++;
      checks++; if (init_cnt + pulses != 0) $display("FAIL train_no_neuron: got %0d required 0", init_cnt + pulses); else passed++;
      checks++; if (rsp_cyc != 3) $display("FAIL train_rsp_latency: got %0d required 3", rsp_cyc); else passed++;
      e = sb.pop_front();
      checks++; if ({rsp_pattern, rsp_iters, rsp_timeout} !== {e.pat, e.iters, e.tmo})
         $display("FAIL train_rsp: got %h/%0d/%b required %h/%0d/%b", rsp_pattern, rsp_iters, rsp_timeout, e.pat, e.iters, e.tmo);
      else passed++;
      consume_rsp();
   endtask

   task automatic test_settle_wait();
      int mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad;
      exp_t e;
      sb.push_back('{pat: 16'h1234, iters: 6'd0, tmo: 1'b0});
      run_cmd(1'b0, 16'h1234, 3, 0, 0, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      checks++; if (mw_cyc != 5) $display("FAIL settle_mw_latency: got %0d required 5", mw_cyc); else passed++;
      e = sb.pop_front();
      checks++; if (rsp_pattern !== e.pat) $display("FAIL settle_rsp_pattern: got %h required %h", rsp_pattern, e.pat); else passed++;
      consume_rsp();
   endtask

   task automatic test_recall();
      int mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad;
      exp_t e;
      neuron_states = 16'h0FFF;
      sb.push_back('{pat: 16'h0FFF, iters: 6'd3, tmo: 1'b0});
      run_cmd(1'b1, 16'h0F0F, 0, 3, 0, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      checks++; if (init_cnt != 1) $display("FAIL recall_init: got %0d required 1", init_cnt); else passed++;
      checks++; if (pulses != 3) $display("FAIL recall_pulses: got %0d required 3", pulses); else passed++;
      checks++; if (mw_cnt != 0) $display("FAIL recall_no_mw: got %0d required 0", mw_cnt); else passed++;
      checks++; if (rsp_cyc != 7) $display("FAIL recall_rsp_latency: got %0d required 7", rsp_cyc); else passed++;
      checks++; if (pi_bad != 0) $display("FAIL recall_pattern_input: %0d bad cycles, required 0", pi_bad); else passed++;
      e = sb.pop_front();
      checks++; if ({rsp_pattern, rsp_iters, rsp_timeout} !== {e.pat, e.iters, e.tmo})
         $display("FAIL recall_rsp: got %h/%0d/%b required %h/%0d/%b", rsp_pattern, rsp_iters, rsp_timeout, e.pat, e.iters, e.tmo);
      else passed++;
      consume_rsp();
   endtask

   task automatic test_timeout();
      int mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad;
      exp_t e;
      neuron_states = 16'hBEEF;
      sb.push_back('{pat: 16'hBEEF, iters: 6'd4, tmo: 1'b1});
      run_cmd(1'b1, 16'h5555, 0, 1000, 0, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      checks++; if (pulses != 4) $display("FAIL timeout_pulses: got %0d required 4", pulses); else passed++;
      checks++; if (overlap != 0) $display("FAIL timeout_overlap: got %0d required 0", overlap); else passed++;
      e = sb.pop_front();
      checks++; if ({rsp_pattern, rsp_iters, rsp_timeout} !== {e.pat, e.iters, e.tmo})
         $display("FAIL timeout_rsp: got %h/%0d/%b required %h/%0d/%b", rsp_pattern, rsp_iters, rsp_timeout, e.pat, e.iters, e.tmo);
      else passed++;
      consume_rsp();
   endtask

   task automatic test_backpressure();
      int mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad;
      int bad;
      exp_t e;
      bad = 0;
      sb.push_back('{pat: 16'hA5A5, iters: 6'd0, tmo: 1'b0});
      run_cmd(1'b0, 16'hA5A5, 0, 0, 0, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_op = 1'b1; cmd_pattern = 16'h7E7E;
         #1;
         if (!rsp_valid || cmd_ready || rsp_pattern !== e.pat || rsp_iters !== e.iters ||
             rsp_timeout !== e.tmo || pattern_input !== 16'hA5A5) bad++;
      end
      checks++; if (bad != 0) $display("FAIL bp_stall: %0d unstable cycles, required 0", bad); else passed++;
      @(negedge clk);
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01)
         $display("FAIL bp_release: got rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
      else passed++;
   endtask

   task automatic test_reset_mid_iter();
      int mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad;
      exp_t e;
      run_cmd(1'b1, 16'h3C3C, 0, 1000, 2, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      checks++; if (pulses != 2) $display("FAIL rst_iter_reached: got %0d required 2", pulses); else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if ({modify_weights, modify_neuron, modify_neuron_using_input, rsp_valid, cmd_ready} !== 5'b00001)
         $display("FAIL rst_iter_state: got mw=%b mn=%b mnui=%b rv=%b cr=%b required 0/0/0/0/1",
                  modify_weights, modify_neuron, modify_neuron_using_input, rsp_valid, cmd_ready);
      else passed++;
      rst = 1'b0; converged = 1'b0;
      sb.push_back('{pat: 16'hC3C3, iters: 6'd0, tmo: 1'b0});
      run_cmd(1'b0, 16'hC3C3, 0, 0, 0, mw_cyc, mw_cnt, init_cnt, pulses, rsp_cyc, overlap, pi_bad);
      e = sb.pop_front();
      checks++; if (rsp_cyc != 3 || rsp_pattern !== e.pat || rsp_iters !== e.iters || rsp_timeout !== e.tmo)
         $display("FAIL rst_then_train: got cyc=%0d %h/%0d/%b required cyc=3 %h/%0d/%b",
                  rsp_cyc, rsp_pattern, rsp_iters, rsp_timeout, e.pat, e.iters, e.tmo);
      else passed++;
      consume_rsp();
   endtask

   initial begin
      test_reset();
      test_train();
      test_settle_wait();
      test_recall();
      test_timeout();
      test_backpressure();
      test_reset_mid_iter();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
